// File: rtl/axi_stream_fifo.sv
// Synchronous valid/ready FIFO with show-ahead read port, occupancy count,
// programmable almost-full/almost-empty flags and a synchronous flush.
module axi_stream_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full, empty, push, pop, mem_we;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == '0);
  assign wready = !full && !flush;
  assign rvalid = !empty && !flush;
  assign push   = wvalid && wready;
  assign pop    = rvalid && rready;
  // A word presented during reset is dropped; keep it out of the array too.
  assign mem_we = push && !reset;

  assign rdata        = rvalid ? mem_q[rptr_q] : '0;
  assign level        = level_q;
  assign almost_full  = (level_q >= LVL_W'(AFULL_LEVEL));
  assign almost_empty = (level_q <= LVL_W'(AEMPTY_LEVEL));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is never cleared; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= wdata;
  end

endmodule
